// File: rtl/commit_trace_unit.sv
// commit_trace_unit: formats one numbered trace record per retired instruction and streams
// them through an FWFT FIFO over a valid/ready port, stopping after the halt record drains.
module commit_trace_unit #(
  parameter int DEPTH      = 8,
  parameter int INUM_W     = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [15:0]       pc,
  input  logic              reg_write,
  input  logic [3:0]        dst_reg,
  input  logic [15:0]       wr_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              hlt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INUM_W+54:0] out_data,
  output logic              trace_stall,
  output logic              overflow,
  output logic              done,
  output logic              timeout,
  output logic [INUM_W-1:0] inst_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = INUM_W + 55;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [W-1:0]      mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q, count;
  logic [INUM_W-1:0] inst_q;
  logic              ovf_q;
  logic [31:0]       cyc_q;
  logic              empty, full, pop, push_try, push;
  logic [1:0]        kind;
  logic [3:0]        rec_reg;
  logic [15:0]       rec_val, rec_addr;
  logic [W-1:0]      rec, head;
  always_comb begin
    count    = wr_q - rd_q;
    empty    = wr_q == rd_q;
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    head     = mem_q[rd_q[AW-1:0]];
    pop      = !empty && out_ready;
    push_try = state_q == RUN && commit_valid;
    // a full FIFO still takes a push when the head leaves in the same cycle
    push     = push_try && (!full || pop);
    kind     = hlt ? 2'd0 : reg_write ? (mem_read ? 2'd2 : 2'd1) : mem_write ? 2'd3 : 2'd0;
    rec_reg  = (!hlt && reg_write) ? dst_reg : 4'd0;
    rec_val  = hlt ? 16'd0 : reg_write ? wr_data : mem_write ? mem_data : 16'd0;
    rec_addr = (!hlt && (reg_write ? mem_read : mem_write)) ? mem_addr : 16'd0;
    rec      = {hlt, kind, inst_q, pc, rec_reg, rec_val, rec_addr};
    state_d  = state_q;
    state_d  = (state_q == RUN && push && hlt) ? DRAIN :
               (state_q == DRAIN && pop && head[W-1]) ? DONE : state_q;
  end
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : head;
  assign trace_stall = count >= (AW+1)'(DEPTH - 1);
  assign overflow    = ovf_q;
  assign done        = state_q == DONE;
  assign timeout     = cyc_q > 32'(MAX_CYCLES);
  assign inst_count  = inst_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      inst_q  <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
      if (push) inst_q <= inst_q + INUM_W'(1);
      if (push_try && !push) ovf_q <= 1'b1;
      cyc_q <= cyc_q + 32'(cyc_q != '1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= rec;
  end
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the trace stream.
module tb_commit_trace_unit;
  localparam int DEPTH = 8;
  localparam int MAXC  = 20;
  typedef struct packed {
    logic cv; logic [15:0] pc; logic rw; logic [3:0] dst; logic [15:0] wd;
    logic mr, mw; logic [15:0] ma, md; logic hlt, rdy;
  } in_t;
  typedef struct {
    logic rst_first; in_t i; logic ev; logic [70:0] ed; logic [15:0] einst;
  } row_t;
  logic clk = 0, rst;
  in_t cur;
  logic out_valid, trace_stall, overflow, done, timeout;
  logic [70:0] out_data;
  logic [15:0] inst_count;
  int vec = 0, miss = 0;
  logic [70:0] mq[$];
  logic [70:0] popped[$];
  logic [15:0] m_inst;
  logic m_ovf, m_done, m_halted;
  logic [31:0] m_cyc;
  row_t tbl[6];

  commit_trace_unit #(.DEPTH(DEPTH), .INUM_W(16), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .commit_valid(cur.cv), .pc(cur.pc), .reg_write(cur.rw),
    .dst_reg(cur.dst), .wr_data(cur.wd), .mem_read(cur.mr), .mem_write(cur.mw),
    .mem_addr(cur.ma), .mem_data(cur.md), .hlt(cur.hlt), .out_valid(out_valid),
    .out_ready(cur.rdy), .out_data(out_data), .trace_stall(trace_stall),
    .overflow(overflow), .done(done), .timeout(timeout), .inst_count(inst_count));

  always #5 clk = ~clk;

  function automatic in_t mkin(logic cv, logic [15:0] pc, logic rw, logic [3:0] dst,
                               logic [15:0] wd, logic mr, logic mw, logic [15:0] ma,
                               logic [15:0] md, logic hlt, logic rdy);
    in_t i;
    i = '{cv, pc, rw, dst, wd, mr, mw, ma, md, hlt, rdy};
    return i;
  endfunction

  function automatic logic [70:0] mk(in_t i, logic [15:0] n);
    logic [1:0] k; logic [3:0] r; logic [15:0] v, a;
    k = 0; r = 0; v = 0; a = 0;
    if (i.hlt) begin end
    else if (i.rw && i.mr) begin k = 2; r = i.dst; v = i.wd; a = i.ma; end
    else if (i.rw) begin k = 1; r = i.dst; v = i.wd; end
    else if (i.mw) begin k = 3; v = i.md; a = i.ma; end
    return {i.hlt, k, n, i.pc, r, v, a};
  endfunction

  task automatic chk(string n, logic [70:0] a, logic [70:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 71'(out_valid), 71'(mq.size() > 0));
    chk("out_data", out_data, mq.size() > 0 ? mq[0] : 71'd0);
    chk("trace_stall", 71'(trace_stall), 71'(mq.size() >= DEPTH - 1));
    chk("overflow", 71'(overflow), 71'(m_ovf));
    chk("done", 71'(done), 71'(m_done));
    chk("timeout", 71'(timeout), 71'(m_cyc > MAXC));
    chk("inst_count", 71'(inst_count), 71'(m_inst));
  endtask

  task automatic step_model(in_t i);
    logic [70:0] r;
    bit pop, att, acc;
    pop = mq.size() > 0 && i.rdy;
    att = !m_halted && i.cv;
    acc = att && (mq.size() < DEPTH || pop);
    if (pop) begin
      r = mq.pop_front();
      popped.push_back(r);
      if (r[70]) m_done = 1;
    end
    if (acc) begin
      mq.push_back(mk(i, m_inst));
      m_inst++;
      if (i.hlt) m_halted = 1;
    end else if (att) m_ovf = 1;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    mq.delete(); popped.delete();
    m_inst = 0; m_ovf = 0; m_done = 0; m_halted = 0; m_cyc = 0;
    check_all();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic cycle(in_t i);
    cur = i;
    #1;
    step_model(i);
    @(posedge clk); #1;
    check_all();
  endtask

  function automatic in_t rw_in(logic [15:0] pc, logic rdy);
    return mkin(1, pc, 1, pc[3:0], pc ^ 16'h5A5A, 0, 0, 0, 0, 0, rdy);
  endfunction

  initial begin
    rst = 0;
    cur = '0;
    tbl[0] = '{1, mkin(1, 16'h0000, 1, 3, 16'h00AB, 0, 0, 0, 0, 0, 1), 1,
               {1'b0, 2'd1, 16'd0, 16'h0000, 4'd3, 16'h00AB, 16'h0000}, 16'd1};
    tbl[1] = '{1, mkin(1, 16'h0004, 1, 5, 16'h1234, 1, 0, 16'h0040, 0, 0, 1), 1,
               {1'b0, 2'd2, 16'd0, 16'h0004, 4'd5, 16'h1234, 16'h0040}, 16'd1};
    tbl[2] = '{0, mkin(1, 16'h0006, 0, 0, 0, 0, 1, 16'h0042, 16'hBEEF, 0, 1), 1,
               {1'b0, 2'd3, 16'd1, 16'h0006, 4'd0, 16'hBEEF, 16'h0042}, 16'd2};
    tbl[3] = '{0, mkin(1, 16'h0008, 1, 7, 16'h0055, 0, 1, 16'h0099, 16'h1111, 0, 1), 1,
               {1'b0, 2'd1, 16'd2, 16'h0008, 4'd7, 16'h0055, 16'h0000}, 16'd3};
    tbl[4] = '{0, mkin(1, 16'h000A, 0, 9, 16'h7777, 0, 0, 16'h3333, 16'h4444, 0, 1), 1,
               {1'b0, 2'd0, 16'd3, 16'h000A, 4'd0, 16'h0000, 16'h0000}, 16'd4};
    tbl[5] = '{0, mkin(0, 16'h000C, 1, 2, 16'h2222, 0, 0, 0, 0, 0, 1), 0, 71'd0, 16'd4};
    #2;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].rst_first) do_reset();
      cycle(tbl[k].i);
      chk($sformatf("tbl%0d_valid", k), 71'(out_valid), 71'(tbl[k].ev));
      chk($sformatf("tbl%0d_data", k), out_data, tbl[k].ed);
      chk($sformatf("tbl%0d_inst", k), 71'(inst_count), 71'(tbl[k].einst));
    end
    // fill to full, overflow, then push while popping a full FIFO
    do_reset();
    for (int k = 0; k < 6; k++) cycle(rw_in(16'(k), 0));
    chk("stall_after6", 71'(trace_stall), 71'd0);
    cycle(rw_in(16'd6, 0));
    chk("stall_after7", 71'(trace_stall), 71'd1);
    cycle(rw_in(16'd7, 0));
    chk("ovf_before9", 71'(overflow), 71'd0);
    cycle(rw_in(16'd8, 0));
    chk("ovf_after9", 71'(overflow), 71'd1);
    chk("inst_after9", 71'(inst_count), 71'd8);
    cycle(rw_in(16'd9, 1));
    chk("full_push_inst", 71'(inst_count), 71'd9);
    chk("full_push_stall", 71'(trace_stall), 71'd1);
    chk("full_push_head", 71'(out_data[67:52]), 71'd1);
    // halt behind three queued records, commits kept asserted afterwards
    do_reset();
    for (int k = 0; k < 3; k++) cycle(rw_in(16'(2 * k), 0));
    cycle(mkin(1, 16'h001E, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 8; k++) cycle(rw_in(16'h0100 + 16'(k), 1));
    chk("halt_pops", 71'(popped.size()), 71'd4);
    if (popped.size() == 4) begin
      chk("halt_bit", 71'(popped[3][70]), 71'd1);
      chk("halt_inum", 71'(popped[3][67:52]), 71'd3);
      chk("halt_pc", 71'(popped[3][51:36]), 71'h1E);
    end
    chk("halt_done", 71'(done), 71'd1);
    chk("halt_empty", 71'(out_valid), 71'd0);
    chk("halt_inst", 71'(inst_count), 71'd4);
    // reset with five records queued and overflow set
    do_reset();
    for (int k = 0; k < 9; k++) cycle(rw_in(16'(k), 0));
    for (int k = 0; k < 3; k++) cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("pre_rst_ovf", 71'(overflow), 71'd1);
    rst = 1;
    #1;
    chk("rst_valid", 71'(out_valid), 71'd0);
    chk("rst_ovf", 71'(overflow), 71'd0);
    chk("rst_inst", 71'(inst_count), 71'd0);
    rst = 0;
    do_reset();
    // timeout boundary
    for (int k = 0; k < MAXC; k++) cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("timeout_at20", 71'(timeout), 71'd0);
    cycle(rw_in(16'h0042, 1));
    chk("timeout_at21", 71'(timeout), 71'd1);
    chk("timeout_stream", 71'(out_valid), 71'd1);
    // random traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      in_t i;
      if ($urandom_range(0, 149) == 0) do_reset();
      i = in_t'({$urandom, $urandom, $urandom});
      i.cv  = $urandom_range(0, 9) < 7;
      i.rdy = $urandom_range(0, 9) < 6;
      i.hlt = $urandom_range(0, 49) == 0;
      cycle(i);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
